uart_rx: RTL

Serial receiver for the UART RX path. Synchronises the asynchronous `rx_in` line, detects the start bit, samples 8 data bits LSB-first at mid-bit, checks the stop bit (and optional parity), and emits each good byte as a one-cycle write strobe. Sits directly upstream of the 16-deep RX byte FIFO:
- `rx_data` drives the FIFO `d_in`.
- `rx_valid` drives the FIFO `wr_en`.
- The FIFO `fifo_full` returns on `fifo_full`.

---
 rtl/uart_rx_if.sv | 35 +++
 rtl/uart_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-side and FIFO-side signals of the UART byte receiver.
// The master modport is the receiver. It consumes the line and the FIFO full flag,
// and drives the byte strobe and the status pulses. The slave modport is its mirror.
interface uart_rx_if;
  logic       rx_in;
  logic       fifo_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       framing_err;
  logic       parity_err;
  logic       overrun_err;

  modport master (
    input  rx_in,
    input  fifo_full,
    output rx_data,
    output rx_valid,
    output busy,
    output framing_err,
    output parity_err,
    output overrun_err
  );

  modport slave (
    output rx_in,
    output fifo_full,
    input  rx_data,
    input  rx_valid,
    input  busy,
    input  framing_err,
    input  parity_err,
    input  overrun_err
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver feeding an RX byte FIFO.
// - Synchronises rx_in through two flops.
// - Qualifies the start bit at mid-bit.
// - Samples 8 data bits LSB first at mid-bit, then checks the stop bit.
// - Emits one registered pulse per completed frame:
//   rx_valid, framing_err, parity_err or overrun_err.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit between the
// data bits and the stop bit. PARITY_ODD selects odd (1) or even (0) parity.
// Without the macro, parity_err is tied low.
module uart_rx #(
  parameter int BAUD_DIV   = 868,
  parameter int PARITY_ODD = 0
) (
  input logic       clk,
  input logic       reset,
  uart_rx_if.master bus
);

  localparam int               CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam bit CFG_OK = (BAUD_DIV >= 8) && ((BAUD_DIV % 2) == 0) &&
                          ((PARITY_ODD == 0) || (PARITY_ODD == 1));

  // Reject parameter sets the bit timing cannot honour.
  generate
    if (!CFG_OK) begin : g_cfg_invalid
      $error("uart_rx: BAUD_DIV must be even and >= 8, PARITY_ODD must be 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = 1'(PARITY_ODD);

  // Even-parity reduction of a data byte.
  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  // Synchroniser and FSM state.
  logic             sync1_r;
  logic             rx_s;
  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;

  // Registered outputs.
  logic [7:0]       rx_data_r;
  logic             valid_r;
  logic             ferr_r;
  logic             oerr_r;
  logic             busy_r;

  // Per-cycle control decoded by the FSM.
  logic             cnt_clr_s;
  logic             shift_en_s;
  logic             emit_valid_s;
  logic             emit_ferr_s;
  logic             emit_oerr_s;

`ifdef UART_RX_PARITY_EN
  logic             par_sample_s;
  logic             emit_perr_s;
  logic             parity_bad_r;
  logic             perr_r;
`endif

  // Two-flop synchroniser for the asynchronous line. Both flops idle high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= bus.rx_in;
      rx_s    <= sync1_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-cycle control. Every sample point clears the bit counter.
  always_comb begin
    state_next_s = state_r;
    cnt_clr_s    = 1'b0;
    shift_en_s   = 1'b0;
    emit_valid_s = 1'b0;
    emit_ferr_s  = 1'b0;
    emit_oerr_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample_s = 1'b0;
    emit_perr_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        cnt_clr_s = 1'b1;
        if (!rx_s) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_clr_s = 1'b1;
          // A line back high at mid-start was a glitch. Drop it silently.
          if (!rx_s) begin
            state_next_s = ST_DATA;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          cnt_clr_s = 1'b0;
        end
      end

      ST_DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_clr_s  = 1'b1;
          shift_en_s = 1'b1;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next_s = ST_PARITY;
`else
            state_next_s = ST_STOP;
`endif
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          cnt_clr_s = 1'b0;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_r == CNT_LAST) begin
          cnt_clr_s    = 1'b1;
          par_sample_s = 1'b1;
          state_next_s = ST_STOP;
        end else begin
          cnt_clr_s = 1'b0;
        end
      end
`endif

      ST_STOP: begin
        if (cnt_r == CNT_LAST) begin
          // Leave at mid-stop so the next start edge is caught promptly.
          cnt_clr_s    = 1'b1;
          state_next_s = ST_IDLE;
          // Outcome priority: framing, then parity, then overrun, then accept.
          if (!rx_s) begin
            emit_ferr_s = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (parity_bad_r) begin
            emit_perr_s = 1'b1;
`endif
          end else if (bus.fifo_full) begin
            emit_oerr_s = 1'b1;
          end else begin
            emit_valid_s = 1'b1;
          end
        end else begin
          cnt_clr_s = 1'b0;
        end
      end

      default: begin
        cnt_clr_s    = 1'b1;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Bit-period counter. It holds at zero in IDLE and restarts at every state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
    end else if (cnt_clr_s) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Data bit index and LSB-first shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      if (state_r != ST_DATA) begin
        bit_idx_r <= 3'd0;
      end else if (shift_en_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end else begin
        bit_idx_r <= bit_idx_r;
      end
      if (shift_en_s) begin
        shift_r <= {rx_s, shift_r[7:1]};
      end else begin
        shift_r <= shift_r;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Compare the received parity bit against the expected parity of the byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_bad_r <= 1'b0;
    end else if (par_sample_s) begin
      parity_bad_r <= rx_s ^ parity8(shift_r) ^ PAR_SENSE;
    end else begin
      parity_bad_r <= parity_bad_r;
    end
  end
`endif

  // Registered frame outcome pulses, busy flag and accepted-byte holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_r <= 8'h00;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
      oerr_r    <= 1'b0;
      busy_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_r    <= 1'b0;
`endif
    end else begin
      valid_r <= emit_valid_s;
      ferr_r  <= emit_ferr_s;
      oerr_r  <= emit_oerr_s;
      busy_r  <= (state_next_s != ST_IDLE);
`ifdef UART_RX_PARITY_EN
      perr_r  <= emit_perr_s;
`endif
      if (emit_valid_s) begin
        rx_data_r <= shift_r;
      end else begin
        rx_data_r <= rx_data_r;
      end
    end
  end

  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = valid_r;
  assign bus.framing_err = ferr_r;
  assign bus.overrun_err = oerr_r;
  assign bus.busy        = busy_r;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err  = perr_r;
`else
  assign bus.parity_err  = 1'b0;
`endif

endmodule
